// File: rtl/dct2_32_loader.sv
// dct2_32_loader
// Collects a serial stream of signed residual samples into 32-sample blocks.
// Two ping-pong banks are used: one fills while the other is presented in
// parallel to a 32-point DCT-II core. With both banks free, the loader takes
// one sample per cycle indefinitely.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    signed sample, row order (index 0 first)
//   in_valid   in_data / in_sop valid
//   in_sop     current sample is index 0 of a new block
//   in_ready   loader accepts a sample this cycle
//   X[0:N-1]   parallel block presented to the DCT core
//   out_valid  X holds a complete block
//   out_ready  consumer takes X this cycle
//   sop_err    one-cycle pulse when a partial block is discarded
module dct2_32_loader #(
  parameter int DW = 16,
  parameter int N  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  output logic signed [DW-1:0] X [0:N-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sop_err
);

  localparam int AW = $clog2(N);

  // Sample storage; contents need no reset because a bank is only
  // presented once its full flag is set.
  logic signed [DW-1:0] bank_q [0:1][0:N-1];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          sop_err_q, sop_err_d;

  logic          accept;
  logic          release_blk;
  logic [AW-1:0] wr_idx;

  always_comb begin
    in_ready    = !full_q[wr_bank_q];
    out_valid   = full_q[rd_bank_q];
    sop_err     = sop_err_q;
    accept      = in_valid && in_ready;
    release_blk = out_valid && out_ready;
    // A start-of-block sample always lands at index 0, overwriting any
    // partial block already in the write bank.
    wr_idx      = in_sop ? '0 : wr_cnt_q;
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    sop_err_d = 1'b0;

    // Release and completion always target different banks: a bank can
    // only complete when it is not full, and rd_bank only releases a full
    // one. Applying both in the same cycle therefore never conflicts.
    if (release_blk) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      if (in_sop) begin
        wr_cnt_d  = AW'(1);
        sop_err_d = (wr_cnt_q != '0);
      end else if (wr_cnt_q == AW'(N-1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      sop_err_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      sop_err_q <= sop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wr_bank_q][wr_idx] <= in_data;
    end
  end

  // Parallel output straight from the read bank; stable while it stays full.
  for (genvar gi = 0; gi < N; gi++) begin : g_x
    assign X[gi] = bank_q[rd_bank_q][gi];
  end

endmodule

// File: tb/tb_dct2_32_loader.sv
module tb_dct2_32_loader;
  localparam int DW = 16;
  localparam int N  = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 sop_err;
  logic signed [DW-1:0] X [0:N-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dct2_32_loader #(.DW(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_ready (in_ready),
    .X        (X),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sop_err  (sop_err)
  );

  typedef struct {
    logic v;
    logic sop;
    int   d;
    logic ordy;
    logic e_rdy;
    logic e_ov;
    logic e_err;
  } vec_t;

  vec_t vt [0:33];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input int d, input logic r);
    in_valid  = v;
    in_sop    = s;
    in_data   = d[DW-1:0];
    out_ready = r;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  // One line per block handed to the consumer.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready)
      $display("xfer t=%0t block taken X[0]=%0d X[31]=%0d", $time, X[0], X[31]);
  end

  initial begin
    int pos[$];
    int ovc;
    int val;

    // ---------------- reset state ----------------
    to_neg();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset sop_err", int'(sop_err), 0);
    to_edge();
    rst = 1'b0;

    // ---------------- single block, table driven ----------------
    for (int j = 0; j < 32; j++)
      vt[j] = '{1'b1, (j == 0), j * 100 - 1600, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[32] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[33] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 34; k++) begin
      drive(vt[k].v, vt[k].sop, vt[k].d, vt[k].ordy);
      to_neg();
      chk($sformatf("vec%0d in_ready", k), int'(in_ready), int'(vt[k].e_rdy));
      chk($sformatf("vec%0d out_valid", k), int'(out_valid), int'(vt[k].e_ov));
      chk($sformatf("vec%0d sop_err", k), int'(sop_err), int'(vt[k].e_err));
      if (k == 32) begin
        for (int i = 0; i < N; i++)
          chk($sformatf("single X[%0d]", i), int'(X[i]), i * 100 - 1600);
      end
      to_edge();
    end

    // ---------------- streaming 4 blocks ----------------
    for (int c = 0; c < 136; c++) begin
      if (c < 128) drive(1'b1, (c % 32 == 0), (c / 32) * 1000 + c % 32, 1'b1);
      else         drive(1'b0, 1'b0, 0, 1'b1);
      to_neg();
      if (c < 128) chk("stream in_ready", int'(in_ready), 1);
      if (out_valid) begin
        pos.push_back(c);
        chk("stream X0", int'(X[0]), (c / 32 - 1) * 1000);
        chk("stream X31", int'(X[31]), (c / 32 - 1) * 1000 + 31);
      end
      to_edge();
    end
    chk("stream pulse count", pos.size(), 4);
    for (int k = 0; k < pos.size() && k < 4; k++)
      chk($sformatf("stream pulse%0d cycle", k), pos[k], 32 * k + 32);

    // ---------------- backpressure ----------------
    for (int j = 0; j < 64; j++) begin
      drive(1'b1, (j % 32 == 0), (j < 32) ? 5000 + j : -3000 - (j - 32), 1'b0);
      to_neg();
      chk("bp in_ready", int'(in_ready), 1);
      if (j == 32 || j == 63) chk("bp X7 hold", int'(X[7]), 5007);
      to_edge();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 9999, 1'b0);
      to_neg();
      chk("bp stalled in_ready", int'(in_ready), 0);
      chk("bp stalled out_valid", int'(out_valid), 1);
      chk("bp stalled X0", int'(X[0]), 5000);
      to_edge();
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    to_neg();
    chk("bp release out_valid", int'(out_valid), 1);
    chk("bp release in_ready", int'(in_ready), 0);
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("bp blk1 out_valid", int'(out_valid), 1);
    chk("bp blk1 in_ready", int'(in_ready), 1);
    chk("bp blk1 X0", int'(X[0]), -3000);
    chk("bp blk1 X31", int'(X[31]), -3031);
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b1);
    to_neg();
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("bp drained out_valid", int'(out_valid), 0);
    to_edge();

    // ---------------- completion and release in the same cycle ----------------
    for (int j = 0; j < 64; j++) begin
      drive(1'b1, (j % 32 == 0), (j < 32) ? 100 + j : 200 + (j - 32), (j == 63));
      to_neg();
      chk("same-cycle in_ready", int'(in_ready), 1);
      to_edge();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("same-cycle out_valid", int'(out_valid), 1);
    chk("same-cycle X0", int'(X[0]), 200);
    chk("same-cycle X31", int'(X[31]), 231);
    chk("same-cycle in_ready after", int'(in_ready), 1);
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b1);
    to_neg();
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("same-cycle drained", int'(out_valid), 0);
    to_edge();

    // ---------------- sop resync ----------------
    ovc = 0;
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, (j == 0), 700 + j, 1'b1);
      to_neg();
      ovc += int'(out_valid);
      to_edge();
    end
    for (int j = 0; j < 32; j++) begin
      drive(1'b1, (j == 0), 4000 + j, 1'b1);
      to_neg();
      if (j == 0) chk("resync sop_err before", int'(sop_err), 0);
      if (j == 1) chk("resync sop_err pulse", int'(sop_err), 1);
      if (j == 2) chk("resync sop_err after", int'(sop_err), 0);
      ovc += int'(out_valid);
      to_edge();
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    to_neg();
    chk("resync early out_valid count", ovc, 0);
    chk("resync out_valid", int'(out_valid), 1);
    chk("resync X0", int'(X[0]), 4000);
    chk("resync X10", int'(X[10]), 4010);
    chk("resync X31", int'(X[31]), 4031);
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("resync drained", int'(out_valid), 0);
    to_edge();

    // ---------------- extreme values ----------------
    for (int j = 0; j < 32; j++) begin
      val = (j % 2 == 1) ? 32767 : -32768;
      drive(1'b1, (j == 0), val, 1'b0);
      to_neg();
      to_edge();
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    to_neg();
    chk("extreme out_valid", int'(out_valid), 1);
    for (int i = 0; i < N; i++)
      chk($sformatf("extreme X[%0d]", i), int'(X[i]), (i % 2 == 1) ? 32767 : -32768);
    to_edge();
    drive(1'b0, 1'b0, 0, 1'b0);

    // ---------------- reset mid-operation ----------------
    for (int j = 0; j < 52; j++) begin
      drive(1'b1, (j % 32 == 0), 8000 + j, 1'b0);
      to_neg();
      to_edge();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    to_neg();
    chk("pre-reset out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset in_ready", int'(in_ready), 1);
    chk("async reset sop_err", int'(sop_err), 0);
    to_edge();
    rst = 1'b0;
    ovc = 0;
    for (int j = 0; j < 40; j++) begin
      drive((j < 32), 1'b0, 6000 + j, 1'b1);
      to_neg();
      if (out_valid) begin
        ovc++;
        chk("post-reset X0", int'(X[0]), 6000);
        chk("post-reset X31", int'(X[31]), 6031);
      end
      to_edge();
    end
    chk("post-reset block count", ovc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
